// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, controller state type and the byte-lane helper
// used by the register-block slave controller.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // ST_ERR1 keeps the encoding reserved; the controller never enters it.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ctrl_state_e;

    // Lanes covered by a 2**size byte transfer starting at lane (addr_lsb mod nbytes).
    function automatic logic [7:0] size_to_strb(input logic [2:0]  size,
                                                input logic [2:0]  addr_lsb,
                                                input int unsigned nbytes);
        logic [15:0] mask;
        int unsigned shift;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << size)) mask[i] = 1'b1;
        end
        shift = 32'(addr_lsb) & (nbytes - 1);
        mask  = mask << shift;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb_addr_check.sv
// Address-phase legality check and byte-strobe generation for one transfer.
module ahb_addr_check
    import ahb_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          DATA_W     = 32,
    parameter int unsigned ADDR_LIMIT = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [2:0]          size,
    output logic                err_pre,
    output logic [DATA_W/8-1:0] wstrb
);

    localparam int NB      = DATA_W / 8;
    localparam int LOG2_NB = $clog2(NB);

    logic [ADDR_W-1:0] align_mask;
    logic [7:0]        strb_full;
    logic              size_bad;
    logic              misaligned;
    logic              out_of_range;

    always_comb begin
        size_bad     = size > 3'(LOG2_NB);
        align_mask   = ADDR_W'((32'd1 << size) - 32'd1);
        misaligned   = |(addr & align_mask);
        out_of_range = {1'b0, addr} >= (ADDR_W + 1)'(ADDR_LIMIT);
        err_pre      = size_bad | misaligned | out_of_range;
        strb_full    = size_to_strb(size, addr[2:0], NB);
        // Illegal transfers never present lanes to the register file.
        wstrb        = err_pre ? '0 : NB'(strb_full);
    end

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave controller for a register block: wait-state insertion,
// two-cycle ERROR response and a single-cycle register access strobe.
module ahb_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 32,
    parameter int          WAIT_STATES = 0,
    parameter int unsigned ADDR_LIMIT  = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                h_sel,
    input  logic [1:0]          h_trans,
    input  logic                h_write,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [2:0]          h_size,
    input  logic                h_ready,
    input  logic                reg_error,
    output logic                h_readyout,
    output logic                h_resp,
    output logic                reg_access,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W/8-1:0] reg_wstrb
);

    ctrl_state_e         state_q,    state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                write_q,    write_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W/8-1:0] wstrb_q,    wstrb_d;
    logic                err_pre_q,  err_pre_d;

    logic                chk_err_pre;
    logic [DATA_W/8-1:0] chk_wstrb;
    logic                accept;
    logic                data_err;
    logic                can_start;

    ahb_addr_check #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ADDR_LIMIT(ADDR_LIMIT)
    ) u_addr_check (
        .addr   (h_addr),
        .size   (h_size),
        .err_pre(chk_err_pre),
        .wstrb  (chk_wstrb)
    );

    always_comb begin
        accept     = h_sel & h_trans[1] & h_ready;
        data_err   = err_pre_q | reg_error;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        err_pre_d  = err_pre_q;
        h_readyout = 1'b1;
        h_resp     = HRESP_OKAY;
        reg_access = 1'b0;
        can_start  = 1'b0;

        case (state_q)
            ST_WAIT: begin
                h_readyout = 1'b0;
                if (wait_cnt_q == 4'd0) state_d = ST_DATA;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            ST_DATA: begin
                // First ERROR cycle holds the bus; the second one reopens it.
                if (data_err) begin
                    h_readyout = 1'b0;
                    h_resp     = HRESP_ERROR;
                    state_d    = ST_ERR2;
                end else begin
                    reg_access = 1'b1;
                    can_start  = 1'b1;
                end
            end
            ST_ERR2: begin
                h_resp    = HRESP_ERROR;
                can_start = 1'b1;
            end
            default: can_start = 1'b1;
        endcase

        if (can_start) begin
            state_d = ST_IDLE;
            if (accept) begin
                write_d   = h_write;
                addr_d    = h_addr;
                wstrb_d   = chk_wstrb;
                err_pre_d = chk_err_pre;
                if (WAIT_STATES > 0) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = ST_DATA;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            err_pre_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            err_pre_q  <= err_pre_d;
        end
    end

    assign reg_write = write_q;
    assign reg_addr  = addr_q;
    assign reg_wstrb = wstrb_q;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Bench for ahb_slave_ctrl: two configurations (0 and 2 wait states, full and
// half address space) checked every cycle against a transfer-level model.
module tb_ahb_slave_ctrl;

    logic clk;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int          WS    = (g == 0) ? 0 : 2;
        localparam int unsigned LIMIT = (g == 0) ? 32'd4096 : 32'd2048;

        logic        reset, h_sel, h_write, h_ready, reg_error;
        logic [1:0]  h_trans;
        logic [11:0] h_addr;
        logic [2:0]  h_size;
        logic        h_readyout, h_resp, reg_access, reg_write;
        logic [11:0] reg_addr;
        logic [3:0]  reg_wstrb;

        // Transfer-level model: the one outstanding transfer and its progress.
        bit          m_active;
        bit          m_err2;
        int          m_wait;
        bit          m_wr;
        logic [11:0] m_addr;
        bit          m_pre;
        logic [3:0]  m_strb;
        bit          e_rdy, e_resp, e_acc, e_can, e_err, m_accept;
        bit          cmp_en;
        bit          fin;

        ahb_slave_ctrl #(
            .ADDR_W     (12),
            .DATA_W     (32),
            .WAIT_STATES(WS),
            .ADDR_LIMIT (LIMIT)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .h_sel     (h_sel),
            .h_trans   (h_trans),
            .h_write   (h_write),
            .h_addr    (h_addr),
            .h_size    (h_size),
            .h_ready   (h_ready),
            .reg_error (reg_error),
            .h_readyout(h_readyout),
            .h_resp    (h_resp),
            .reg_access(reg_access),
            .reg_write (reg_write),
            .reg_addr  (reg_addr),
            .reg_wstrb (reg_wstrb)
        );

        function automatic bit pre_model(input logic [11:0] a, input logic [2:0] sz);
            int unsigned addr_u;
            int unsigned bytes;
            addr_u = 32'(a);
            if (sz > 3'd2) return 1'b1;
            bytes = 32'd1 << sz;
            return ((addr_u % bytes) != 0) || (addr_u >= LIMIT);
        endfunction

        function automatic logic [3:0] strb_model(input logic [11:0] a, input logic [2:0] sz);
            logic [3:0]  s;
            int unsigned lo;
            int unsigned n;
            s = 4'b0000;
            if (pre_model(a, sz)) return s;
            lo = 32'(a) % 4;
            n  = 32'd1 << sz;
            for (int lane = 0; lane < 4; lane++)
                s[lane] = (lane >= int'(lo)) && (lane < int'(lo + n));
            return s;
        endfunction

        task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL ws=%0d %s: got %0h expected %0h at %0t", WS, name, act, exp, $time);
            end
        endtask

        task automatic set_inputs(input bit rst, input bit sel, input logic [1:0] tr, input bit wr,
                                  input logic [11:0] a, input logic [2:0] sz, input bit rerr,
                                  input bit drop);
            reset = rst; h_sel = sel; h_trans = tr; h_write = wr;
            h_addr = a; h_size = sz; reg_error = rerr;
            e_err = 1'b0;
            if (m_err2) begin
                e_rdy = 1'b1; e_resp = 1'b1; e_acc = 1'b0; e_can = 1'b1;
            end else if (m_active && m_wait > 0) begin
                e_rdy = 1'b0; e_resp = 1'b0; e_acc = 1'b0; e_can = 1'b0;
            end else if (m_active) begin
                e_err = m_pre || rerr;
                e_rdy = !e_err; e_resp = e_err; e_acc = !e_err; e_can = !e_err;
            end else begin
                e_rdy = 1'b1; e_resp = 1'b0; e_acc = 1'b0; e_can = 1'b1;
            end
            // Another slave may stall the bus only while this one has nothing in flight.
            h_ready  = (drop && !m_active && !m_err2) ? 1'b0 : e_rdy;
            m_accept = !rst && e_can && sel && tr[1] && h_ready;
        endtask

        task automatic set_idle(input bit rerr);
            set_inputs(1'b0, 1'b0, 2'b00, 1'b0, 12'h000, 3'd0, rerr, 1'b0);
        endtask

        task automatic finish_cycle();
            @(negedge clk);
            @(posedge clk);
            if (reset) begin
                m_active = 1'b0; m_err2 = 1'b0; m_wait = 0;
                m_wr = 1'b0; m_addr = '0; m_pre = 1'b0; m_strb = '0;
            end else begin
                m_err2 = 1'b0;
                if (m_active) begin
                    if (m_wait > 0) m_wait--;
                    else begin
                        m_active = 1'b0;
                        m_err2   = e_err;
                    end
                end
                if (m_accept) begin
                    m_active = 1'b1; m_wait = WS; m_wr = h_write; m_addr = h_addr;
                    m_pre = pre_model(h_addr, h_size); m_strb = strb_model(h_addr, h_size);
                end
            end
            #1;
        endtask

        // After an accepted address phase: walk the wait states, stop in the data cycle.
        task automatic wait_to_data(input bit rerr);
            for (int i = 0; i < WS; i++) begin
                set_idle(1'b0);
                #1 chk("wait_readyout", 32'(h_readyout), 32'd0);
                finish_cycle();
            end
            set_idle(rerr);
            #1;
        endtask

        task automatic addr_phase(input bit wr, input logic [11:0] a, input logic [2:0] sz,
                                  input bit rerr);
            set_inputs(1'b0, 1'b1, 2'b10, wr, a, sz, 1'b0, 1'b0);
            finish_cycle();
            wait_to_data(rerr);
        endtask

        always @(negedge clk) begin
            if (cmp_en) begin
                chk("h_readyout", 32'(h_readyout), 32'(e_rdy));
                chk("h_resp",     32'(h_resp),     32'(e_resp));
                chk("reg_access", 32'(reg_access), 32'(e_acc));
                chk("reg_write",  32'(reg_write),  32'(m_wr));
                chk("reg_addr",   32'(reg_addr),   32'(m_addr));
                chk("reg_wstrb",  32'(reg_wstrb),  32'(m_strb));
            end
        end

        initial begin
            cmp_en = 1'b0; fin = 1'b0;
            m_active = 1'b0; m_err2 = 1'b0; m_wait = 0;
            m_wr = 1'b0; m_addr = '0; m_pre = 1'b0; m_strb = '0;
            set_inputs(1'b1, 1'b0, 2'b00, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
            repeat (3) finish_cycle();
            set_idle(1'b0);
            cmp_en = 1'b1;
            #1;
            chk("rst_readyout", 32'(h_readyout), 32'd1);
            chk("rst_resp",     32'(h_resp),     32'd0);
            chk("rst_access",   32'(reg_access), 32'd0);
            chk("rst_addr",     32'(reg_addr),   32'd0);
            chk("rst_wstrb",    32'(reg_wstrb),  32'd0);
            finish_cycle();

            addr_phase(1'b1, 12'h004, 3'd2, 1'b0);
            chk("word_access", 32'(reg_access), 32'd1);
            chk("word_write",  32'(reg_write),  32'd1);
            chk("word_addr",   32'(reg_addr),   32'h004);
            chk("word_wstrb",  32'(reg_wstrb),  32'hF);
            chk("word_rdy",    32'(h_readyout), 32'd1);
            chk("word_resp",   32'(h_resp),     32'd0);
            finish_cycle();

            addr_phase(1'b1, 12'h003, 3'd0, 1'b0);
            chk("byte_wstrb",  32'(reg_wstrb),  32'h8);
            chk("byte_access", 32'(reg_access), 32'd1);
            finish_cycle();

            addr_phase(1'b1, 12'h002, 3'd1, 1'b0);
            chk("half_wstrb", 32'(reg_wstrb), 32'hC);
            finish_cycle();

            addr_phase(1'b0, 12'h006, 3'd2, 1'b0);
            chk("unal_rdy1",    32'(h_readyout), 32'd0);
            chk("unal_resp1",   32'(h_resp),     32'd1);
            chk("unal_access1", 32'(reg_access), 32'd0);
            finish_cycle();
            set_idle(1'b0);
            #1;
            chk("unal_rdy2",    32'(h_readyout), 32'd1);
            chk("unal_resp2",   32'(h_resp),     32'd1);
            chk("unal_access2", 32'(reg_access), 32'd0);
            finish_cycle();

            addr_phase(1'b0, 12'h008, 3'd3, 1'b0);
            chk("size3_rdy",  32'(h_readyout), 32'd0);
            chk("size3_resp", 32'(h_resp),     32'd1);
            finish_cycle();
            set_idle(1'b0);
            finish_cycle();

            addr_phase(1'b0, 12'h008, 3'd2, 1'b1);
            chk("rerr_rdy1",   32'(h_readyout), 32'd0);
            chk("rerr_resp1",  32'(h_resp),     32'd1);
            chk("rerr_access", 32'(reg_access), 32'd0);
            finish_cycle();
            set_inputs(1'b0, 1'b1, 2'b10, 1'b0, 12'h00C, 3'd2, 1'b0, 1'b0);
            #1;
            chk("rerr_rdy2",  32'(h_readyout), 32'd1);
            chk("rerr_resp2", 32'(h_resp),     32'd1);
            finish_cycle();
            wait_to_data(1'b0);
            chk("err2_accept_access", 32'(reg_access), 32'd1);
            chk("err2_accept_addr",   32'(reg_addr),   32'h00C);
            chk("err2_accept_resp",   32'(h_resp),     32'd0);
            finish_cycle();

            addr_phase(1'b0, 12'h010, 3'd2, 1'b0);
            chk("b2b_first_access", 32'(reg_access), 32'd1);
            chk("b2b_first_addr",   32'(reg_addr),   32'h010);
            set_inputs(1'b0, 1'b1, 2'b10, 1'b0, 12'h014, 3'd2, 1'b0, 1'b0);
            finish_cycle();
            wait_to_data(1'b0);
            chk("b2b_second_access", 32'(reg_access), 32'd1);
            chk("b2b_second_addr",   32'(reg_addr),   32'h014);
            finish_cycle();

            addr_phase(1'b0, 12'h800, 3'd2, 1'b0);
            chk("limit_resp", 32'(h_resp), 32'(32'h800 >= LIMIT));
            finish_cycle();
            set_idle(1'b0);
            finish_cycle();
            addr_phase(1'b0, 12'h7FC, 3'd2, 1'b0);
            chk("below_limit_access", 32'(reg_access), 32'd1);
            finish_cycle();

            set_inputs(1'b0, 1'b1, 2'b01, 1'b1, 12'h020, 3'd2, 1'b0, 1'b0);
            #1 chk("busy_rdy", 32'(h_readyout), 32'd1);
            finish_cycle();
            set_inputs(1'b0, 1'b1, 2'b00, 1'b1, 12'h024, 3'd2, 1'b0, 1'b0);
            #1 chk("idle_rdy", 32'(h_readyout), 32'd1);
            finish_cycle();
            set_idle(1'b0);
            #1;
            chk("no_capture_addr", 32'(reg_addr),   32'h7FC);
            chk("no_capture_acc",  32'(reg_access), 32'd0);
            finish_cycle();

            set_inputs(1'b0, 1'b1, 2'b10, 1'b1, 12'h030, 3'd2, 1'b0, 1'b0);
            finish_cycle();
            set_inputs(1'b1, 1'b0, 2'b00, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
            finish_cycle();
            set_idle(1'b0);
            #1;
            chk("midrst_rdy",    32'(h_readyout), 32'd1);
            chk("midrst_access", 32'(reg_access), 32'd0);
            chk("midrst_addr",   32'(reg_addr),   32'd0);
            finish_cycle();

            repeat (400) begin
                bit          rst, sel, wr, rerr, drop;
                logic [1:0]  tr;
                logic [2:0]  sz;
                logic [11:0] a;
                int          r;
                rst  = ($urandom_range(0, 99) == 0);
                sel  = ($urandom_range(0, 9) < 8);
                tr   = 2'($urandom_range(0, 3));
                wr   = 1'($urandom_range(0, 1));
                r    = int'($urandom_range(0, 9));
                sz   = (r == 9) ? 3'($urandom_range(3, 7)) : 3'(r % 3);
                a    = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                                   : 12'($urandom_range(0, 2100));
                if ($urandom_range(0, 9) < 6 && sz <= 3'd2)
                    a = a & ~12'((32'd1 << sz) - 32'd1);
                rerr = ($urandom_range(0, 9) == 0);
                drop = ($urandom_range(0, 7) == 0);
                set_inputs(rst, sel, tr, wr, a, sz, rerr, drop);
                finish_cycle();
            end
            set_idle(1'b0);
            finish_cycle();
            fin = 1'b1;
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
    end

    initial begin : finisher
        while (!(cfg[0].fin && cfg[1].fin)) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected both configurations done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
